// File: rtl/run_timer.sv
// run_timer: mm:ss stopwatch with start/stop/clear and BCD digit outputs.
// Ports: CLK_50M, nCLR (async low), TICK_IN, BTN_SS, BTN_CLR in;
// SEC_L/SEC_H/MIN_L/MIN_H, RUNNING, SEC_PULSE, WRAP out.
// Define RUN_TIMER_ALARM_EN to add the ALARM output.
module run_timer #(
  parameter int SATURATE     = 0,
  parameter int ALARM_TIME_S = 30
) (
  input  logic       CLK_50M,
  input  logic       nCLR,
  input  logic       TICK_IN,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  output logic [3:0] SEC_L,
  output logic [3:0] SEC_H,
  output logic [3:0] MIN_L,
  output logic [3:0] MIN_H,
  output logic       RUNNING,
  output logic       SEC_PULSE,
  output logic       WRAP
`ifdef RUN_TIMER_ALARM_EN
  ,
  output logic       ALARM
`endif
);

  if (ALARM_TIME_S < 0 || ALARM_TIME_S > 3599) begin : g_bad_alarm
    $error("run_timer: ALARM_TIME_S out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t     state;
  logic [2:0] tick_sr;
  logic [2:0] ss_sr;
  logic [2:0] clr_sr;
  logic [1:0] warm;
  logic [2:0] arm;
  logic       tick_e;
  logic       ss_e;
  logic       clr_e;

  logic [3:0] sl_nx;
  logic [3:0] sh_nx;
  logic [3:0] ml_nx;
  logic [3:0] mh_nx;
  logic       at_max;

  // An input only arms once its synchronised level has been seen low
  // after reset, so a level already high at release is not an edge.
  assign tick_e = tick_sr[1] & ~tick_sr[2] & arm[0];
  assign ss_e   = ss_sr[1] & ~ss_sr[2] & arm[1];
  assign clr_e  = clr_sr[1] & ~clr_sr[2] & arm[2];

  assign at_max = (SEC_L == 4'd9) && (SEC_H == 4'd5) &&
                  (MIN_L == 4'd9) && (MIN_H == 4'd5);

  always_comb begin
    sl_nx = SEC_L + 4'd1;
    sh_nx = SEC_H;
    ml_nx = MIN_L;
    mh_nx = MIN_H;
    if (SEC_L == 4'd9) begin
      sl_nx = 4'd0;
      sh_nx = SEC_H + 4'd1;
      if (SEC_H == 4'd5) begin
        sh_nx = 4'd0;
        ml_nx = MIN_L + 4'd1;
        if (MIN_L == 4'd9) begin
          ml_nx = 4'd0;
          mh_nx = (MIN_H == 4'd5) ? 4'd0 : MIN_H + 4'd1;
        end
      end
    end
  end

`ifdef RUN_TIMER_ALARM_EN
  logic [11:0] elap_nx;
  logic        alarm_hit;

  assign elap_nx = 12'(mh_nx) * 12'd600 + 12'(ml_nx) * 12'd60 +
                   12'(sh_nx) * 12'd10 + 12'(sl_nx);
  // The wrap to 00:00 never raises the alarm.
  assign alarm_hit = !at_max && (elap_nx == 12'(ALARM_TIME_S));
`endif

  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      tick_sr   <= '0;
      ss_sr     <= '0;
      clr_sr    <= '0;
      warm      <= '0;
      arm       <= '0;
      state     <= IDLE;
      SEC_L     <= '0;
      SEC_H     <= '0;
      MIN_L     <= '0;
      MIN_H     <= '0;
      RUNNING   <= 1'b0;
      SEC_PULSE <= 1'b0;
      WRAP      <= 1'b0;
`ifdef RUN_TIMER_ALARM_EN
      ALARM     <= 1'b0;
`endif
    end else begin
      tick_sr   <= {tick_sr[1:0], TICK_IN};
      ss_sr     <= {ss_sr[1:0], BTN_SS};
      clr_sr    <= {clr_sr[1:0], BTN_CLR};
      if (!warm[1]) warm <= warm + 2'd1;
      arm       <= arm | ({3{warm[1]}} &
                   ~{clr_sr[1], ss_sr[1], tick_sr[1]});
      SEC_PULSE <= 1'b0;
      if (SATURATE == 0) WRAP <= 1'b0;
      if (clr_e) begin
        state   <= IDLE;
        RUNNING <= 1'b0;
        SEC_L   <= '0;
        SEC_H   <= '0;
        MIN_L   <= '0;
        MIN_H   <= '0;
        WRAP    <= 1'b0;
`ifdef RUN_TIMER_ALARM_EN
        ALARM   <= 1'b0;
`endif
      end else begin
        if (tick_e && state == RUN) begin
          if (at_max && SATURATE != 0) begin
            WRAP <= 1'b1;
          end else begin
            SEC_L     <= sl_nx;
            SEC_H     <= sh_nx;
            MIN_L     <= ml_nx;
            MIN_H     <= mh_nx;
            SEC_PULSE <= 1'b1;
            if (at_max) WRAP <= 1'b1;
`ifdef RUN_TIMER_ALARM_EN
            if (alarm_hit) ALARM <= 1'b1;
`endif
          end
        end
        if (ss_e) begin
          case (state)
            IDLE: begin
              state   <= RUN;
              RUNNING <= 1'b1;
            end
            RUN: begin
              state   <= PAUSE;
              RUNNING <= 1'b0;
            end
            PAUSE: begin
              state   <= RUN;
              RUNNING <= 1'b1;
            end
            default: begin
              state   <= IDLE;
              RUNNING <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_run_timer.sv
// tb_run_timer: table vectors, scoreboard of counted seconds and
// hand sequences for wrap, saturate, collisions, reset and alarm.
module tb_run_timer;

  logic       CLK_50M = 1'b0;
  logic       nCLR    = 1'b0;
  logic       TICK_IN = 1'b0;
  logic       BTN_SS  = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic [3:0] sl0, sh0, ml0, mh0, sl1, sh1, ml1, mh1;
  logic       run0, pul0, wr0, run1, pul1, wr1;
`ifdef RUN_TIMER_ALARM_EN
  logic       al0, al1;
`endif

  always #10 CLK_50M = ~CLK_50M;

  run_timer #(.SATURATE(0), .ALARM_TIME_S(3)) u0 (
    .CLK_50M(CLK_50M), .nCLR(nCLR), .TICK_IN(TICK_IN),
    .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
    .SEC_L(sl0), .SEC_H(sh0), .MIN_L(ml0), .MIN_H(mh0),
    .RUNNING(run0), .SEC_PULSE(pul0), .WRAP(wr0)
`ifdef RUN_TIMER_ALARM_EN
    , .ALARM(al0)
`endif
  );

  run_timer #(.SATURATE(1)) u1 (
    .CLK_50M(CLK_50M), .nCLR(nCLR), .TICK_IN(TICK_IN),
    .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
    .SEC_L(sl1), .SEC_H(sh1), .MIN_L(ml1), .MIN_H(mh1),
    .RUNNING(run1), .SEC_PULSE(pul1), .WRAP(wr1)
`ifdef RUN_TIMER_ALARM_EN
    , .ALARM(al1)
`endif
  );

  typedef struct packed {
    logic [15:0] t;
    logic        w;
    logic        a;
  } exp_t;

  typedef struct {
    bit ss;
    bit clr;
    int ticks;
    int exp_s;
    bit exp_run;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cnt0  = 0;
  int   cnt1  = 0;
  int   st    = 0;
  bit   alm   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  vec_t tbl[7];

  function automatic logic [15:0] bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK_50M) begin
    if (pul0 === 1'b1) begin
      if (q0.size() == 0) chk("sb0_extra_pulse", 1, 0);
      else begin
        m0 = q0.pop_front();
        chk("sb0_time", {mh0, ml0, sh0, sl0}, m0.t);
        chk("sb0_wrap", wr0, m0.w);
`ifdef RUN_TIMER_ALARM_EN
        chk("sb0_alarm", al0, m0.a);
`endif
      end
    end
    if (pul1 === 1'b1) begin
      if (q1.size() == 0) chk("sb1_extra_pulse", 1, 0);
      else begin
        m1 = q1.pop_front();
        chk("sb1_time", {mh1, ml1, sh1, sl1}, m1.t);
        chk("sb1_limit", wr1, m1.w);
      end
    end
  end

  task automatic tick(input bit ss, input bit clr, input bit lat);
    bit   c0, c1, a_prev;
    exp_t e;
    @(negedge CLK_50M);
    TICK_IN = 1'b1;
    BTN_SS  = ss;
    BTN_CLR = clr;
    c0 = 0;
    c1 = 0;
    a_prev = alm;
    if (clr) begin
      st = 0; cnt0 = 0; cnt1 = 0; alm = 0;
    end else begin
      if (st == 1) begin
        c0 = 1;
        e.w = (cnt0 == 3599);
        cnt0 = (cnt0 + 1) % 3600;
        if (!e.w && cnt0 == 3) alm = 1;
        e.t = bcd(cnt0);
        e.a = alm;
        q0.push_back(e);
        if (cnt1 < 3599) begin
          c1 = 1;
          cnt1++;
          e.t = bcd(cnt1);
          e.w = 0;
          q1.push_back(e);
        end
      end
      if (ss) st = (st == 1) ? 2 : 1;
    end
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    TICK_IN = 1'b0;
    BTN_SS  = 1'b0;
    BTN_CLR = 1'b0;
    if (lat) begin
      chk("lat_early0", pul0, 0);
      chk("lat_early1", pul1, 0);
`ifdef RUN_TIMER_ALARM_EN
      chk("alarm_early", al0, a_prev);
`endif
    end
    @(negedge CLK_50M);
    if (lat) begin
      chk("lat_pulse0", pul0, c0);
      chk("lat_pulse1", pul1, c1);
    end
    @(negedge CLK_50M);
    if (lat) begin
      chk("lat_late0", pul0, 0);
      chk("lat_late1", pul1, 0);
    end
  endtask

  task automatic press(input bit ss, input bit clr);
    @(negedge CLK_50M);
    BTN_SS  = ss;
    BTN_CLR = clr;
    if (clr) begin
      st = 0; cnt0 = 0; cnt1 = 0; alm = 0;
    end else if (ss) st = (st == 1) ? 2 : 1;
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    BTN_SS  = 1'b0;
    BTN_CLR = 1'b0;
    @(negedge CLK_50M);
    @(negedge CLK_50M);
  endtask

  initial begin
    tbl[0] = '{1, 0, 5, 5, 1};
    tbl[1] = '{0, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 59, 59, 1};
    tbl[3] = '{0, 0, 1, 60, 1};
    tbl[4] = '{1, 0, 3, 60, 0};
    tbl[5] = '{1, 0, 2, 62, 1};
    tbl[6] = '{0, 1, 0, 0, 0};

    repeat (3) @(negedge CLK_50M);
    chk("rst_time0", {mh0, ml0, sh0, sl0}, 0);
    chk("rst_time1", {mh1, ml1, sh1, sl1}, 0);
    chk("rst_run0", run0, 0);
    chk("rst_pulse0", pul0, 0);
    chk("rst_wrap0", wr0, 0);
    nCLR = 1'b1;
    repeat (5) @(negedge CLK_50M);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].ss || tbl[i].clr) press(tbl[i].ss, tbl[i].clr);
      for (int j = 0; j < tbl[i].ticks; j++) tick(0, 0, 1);
      chk("vec_time0", {mh0, ml0, sh0, sl0}, bcd(tbl[i].exp_s));
      chk("vec_time1", {mh1, ml1, sh1, sl1}, bcd(tbl[i].exp_s));
      chk("vec_run0", run0, tbl[i].exp_run);
      chk("vec_nowrap0", wr0, 0);
    end

    press(1, 0);
    repeat (12) tick(0, 0, 0);
    chk("pre_both_time", {mh0, ml0, sh0, sl0}, bcd(12));
    press(1, 1);
    chk("both_time", {mh0, ml0, sh0, sl0}, 0);
    chk("both_run", run0, 0);
    repeat (4) @(negedge CLK_50M);
    chk("both_run_late", run0, 0);

    press(1, 0);
    repeat (3) tick(0, 0, 1);
    tick(1, 0, 1);
    chk("tick_ss_time", {mh0, ml0, sh0, sl0}, bcd(4));
    chk("tick_ss_run", run0, 0);
    tick(0, 1, 1);
    chk("tick_clr_time", {mh0, ml0, sh0, sl0}, 0);
    chk("tick_clr_run", run0, 0);

    press(1, 0);
    repeat (3599) tick(0, 0, 0);
    chk("max_time0", {mh0, ml0, sh0, sl0}, bcd(3599));
    chk("max_time1", {mh1, ml1, sh1, sl1}, bcd(3599));
    tick(0, 0, 1);
    chk("wrap_one_cycle", wr0, 0);
    chk("wrap_running", run0, 1);
    chk("wrap_time0", {mh0, ml0, sh0, sl0}, 0);
    chk("sat_hold", {mh1, ml1, sh1, sl1}, bcd(3599));
    chk("sat_limit", wr1, 1);
    repeat (2) tick(0, 0, 1);
    chk("sat_hold3", {mh1, ml1, sh1, sl1}, bcd(3599));
    chk("sat_limit3", wr1, 1);
    chk("wrap_time2", {mh0, ml0, sh0, sl0}, bcd(2));
    press(0, 1);
    chk("sat_clr_time", {mh1, ml1, sh1, sl1}, 0);
    chk("sat_clr_limit", wr1, 0);
    chk("sat_clr_run", run1, 0);

    press(1, 0);
    repeat (2) tick(0, 0, 0);
    @(negedge CLK_50M);
    BTN_SS  = 1'b1;
    TICK_IN = 1'b1;
    #3 nCLR = 1'b0;
    st = 0; cnt0 = 0; cnt1 = 0; alm = 0;
    #1;
    chk("arst_time", {mh0, ml0, sh0, sl0}, 0);
    chk("arst_run", run0, 0);
    chk("arst_pulse", pul0, 0);
    chk("arst_wrap", wr0, 0);
`ifdef RUN_TIMER_ALARM_EN
    chk("arst_alarm", al0, 0);
`endif
    repeat (3) @(negedge CLK_50M);
    nCLR = 1'b1;
    repeat (6) @(negedge CLK_50M);
    chk("no_spurious_ss", run0, 0);
    chk("no_spurious_time", {mh0, ml0, sh0, sl0}, 0);
    BTN_SS  = 1'b0;
    TICK_IN = 1'b0;
    repeat (3) @(negedge CLK_50M);
    tick(0, 0, 1);
    chk("idle_tick", {mh0, ml0, sh0, sl0}, 0);

    press(1, 0);
    repeat (2) tick(0, 0, 1);
`ifdef RUN_TIMER_ALARM_EN
    chk("alarm_before", al0, 0);
`endif
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("post_time", {mh0, ml0, sh0, sl0}, bcd(4));
`ifdef RUN_TIMER_ALARM_EN
    chk("alarm_held", al0, 1);
`endif

    repeat (4) @(negedge CLK_50M);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
